// File: rtl/if_id_if.sv
// Fetch/decode handshake bundle for the IF/ID boundary stage.
// slave is the stage side, master is the fetch+decode side.
interface if_id_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [4:0]  out_shamt;
   logic [5:0]  out_funct;
   logic [15:0] out_imm;
   logic [25:0] out_jtarget;
   logic        out_is_nop;

   modport slave (
      input  in_valid, in_instr, in_pc, flush, out_ready,
      output in_ready, out_valid, out_pc, out_pc_plus4,
      output out_opcode, out_rs, out_rt, out_rd, out_shamt,
      output out_funct, out_imm, out_jtarget, out_is_nop
   );

   modport master (
      output in_valid, in_instr, in_pc, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_pc_plus4,
      input  out_opcode, out_rs, out_rt, out_rd, out_shamt,
      input  out_funct, out_imm, out_jtarget, out_is_nop
   );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID boundary: 2-entry elastic queue of {instr, pc} with
// branch flush, splitting the head instruction into decode fields.
module if_id_stage (
   input  logic clk,
   input  logic rst_n,
   if_id_if.slave bus
);
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   entry_t     mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] cnt_q, cnt_d;

   logic   push, pop, vld;
   entry_t head, hd;

   assign bus.in_ready = (cnt_q != 2'd2);
   assign vld  = (cnt_q != 2'd0);
   assign push = bus.in_valid & bus.in_ready & ~bus.flush;
   assign pop  = vld & bus.out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (bus.flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         cnt_d    = 2'd0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push) mem_q[wr_ptr_q] <= '{instr: bus.in_instr, pc: bus.in_pc};
      end
   end

   // Every field reads as zero while the queue is empty.
   assign head = mem_q[rd_ptr_q];
   assign hd   = vld ? head : '0;

   assign bus.out_valid    = vld;
   assign bus.out_pc       = hd.pc;
   assign bus.out_pc_plus4 = vld ? (head.pc + 32'd4) : 32'd0;
   assign bus.out_opcode   = hd.instr[31:26];
   assign bus.out_rs       = hd.instr[25:21];
   assign bus.out_rt       = hd.instr[20:16];
   assign bus.out_rd       = hd.instr[15:11];
   assign bus.out_shamt    = hd.instr[10:6];
   assign bus.out_funct    = hd.instr[5:0];
   assign bus.out_imm      = hd.instr[15:0];
   assign bus.out_jtarget  = hd.instr[25:0];
   assign bus.out_is_nop   = vld & (head.instr == 32'h0000_0000);
endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: stimulus queues expected entries,
// a negedge monitor compares the head whenever out_valid is high.
module tb_if_id_stage;
   logic clk = 1'b0;
   logic rst_n;
   if_id_if bus ();

   if_id_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [31:0] ins, input logic [31:0] pc,
                       input bit acc);
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      bus.in_pc    = pc;
      @(negedge clk);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, acc});
      @(posedge clk);
      if (acc) exp_q.push_back('{instr: ins, pc: pc});
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
      chk("drain_left", exp_q.size(), 0);
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_pc", bus.out_pc, 32'hxxxx_xxxx);
            end else begin
               exp_t e;
               e = exp_q[0];
               chk("mon_pc", bus.out_pc, e.pc);
               chk("mon_pc4", bus.out_pc_plus4, e.pc + 32'd4);
               chk("mon_fields", {bus.out_opcode, bus.out_rs, bus.out_rt,
                   bus.out_rd, bus.out_shamt, bus.out_funct}, e.instr);
               chk("mon_imm", {16'd0, bus.out_imm}, {16'd0, e.instr[15:0]});
               chk("mon_jt", {6'd0, bus.out_jtarget}, {6'd0, e.instr[25:0]});
               chk("mon_nop", {31'd0, bus.out_is_nop},
                   {31'd0, (e.instr == 32'd0)});
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_qsize", exp_q.size(), 0);
            chk("idle_pc", bus.out_pc, 0);
            chk("idle_pc4", bus.out_pc_plus4, 0);
            chk("idle_fields", {bus.out_opcode, bus.out_rs, bus.out_rt,
                bus.out_rd, bus.out_shamt, bus.out_funct}, 0);
            chk("idle_nop", {31'd0, bus.out_is_nop}, 0);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      #3;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
      chk("rst_pc", bus.out_pc, 0);
      chk("rst_pc4", bus.out_pc_plus4, 0);
      chk("rst_nop", {31'd0, bus.out_is_nop}, 0);
      #9 rst_n = 1'b1;
      cyc(1);

      // single push
      push(32'h2108_FFFF, 32'h0040_0000, 1'b1);
      chk("t1_valid", {31'd0, bus.out_valid}, 1);
      chk("t1_opcode", {26'd0, bus.out_opcode}, 32'h08);
      chk("t1_rs", {27'd0, bus.out_rs}, 8);
      chk("t1_rt", {27'd0, bus.out_rt}, 8);
      chk("t1_imm", {16'd0, bus.out_imm}, 32'hFFFF);
      chk("t1_pc4", bus.out_pc_plus4, 32'h0040_0004);
      drain();

      // fill under stall
      bus.out_ready = 1'b0;
      push(32'h8C22_0010, 32'h100, 1'b1);
      push(32'h0043_2020, 32'h104, 1'b1);
      chk("t2_full_ready", {31'd0, bus.in_ready}, 0);
      push(32'hDEAD_BEEF, 32'h108, 1'b0);
      chk("t2_hold_pc", bus.out_pc, 32'h100);
      bus.out_ready = 1'b1;
      chk("t2_pop0", bus.out_pc, 32'h100);
      cyc(1);
      chk("t2_pop1", bus.out_pc, 32'h104);
      cyc(1);
      chk("t2_empty", {31'd0, bus.out_valid}, 0);

      // streaming
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++)
         push(32'h2000_0000 | i, i * 4, 1'b1);
      cyc(1);
      chk("t3_empty", {31'd0, bus.out_valid}, 0);

      // flush with simultaneous push
      bus.out_ready = 1'b0;
      push(32'h1111_1111, 32'h300, 1'b1);
      push(32'h2222_2222, 32'h304, 1'b1);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_instr = 32'h3333_3333;
      bus.in_pc    = 32'h200;
      @(posedge clk);
      exp_q.delete();
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("t4_valid", {31'd0, bus.out_valid}, 0);
      chk("t4_ready", {31'd0, bus.in_ready}, 1);
      cyc(1);
      push(32'h4444_4444, 32'h400, 1'b1);
      chk("t4_repush", bus.out_pc, 32'h400);
      drain();

      // boundary fields
      bus.out_ready = 1'b0;
      push(32'h0000_0000, 32'hFFFF_FFFC, 1'b1);
      chk("t5_nop", {31'd0, bus.out_is_nop}, 1);
      chk("t5_pc4_wrap", bus.out_pc_plus4, 0);
      drain();
      bus.out_ready = 1'b0;
      push(32'h0810_0000, 32'h500, 1'b1);
      chk("t5_opcode", {26'd0, bus.out_opcode}, 2);
      chk("t5_jt", {6'd0, bus.out_jtarget}, 32'h010_0000);
      drain();

      // async reset mid-stream
      bus.out_ready = 1'b0;
      push(32'h5555_5555, 32'h580, 1'b1);
      push(32'h6666_6666, 32'h584, 1'b1);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("t6_valid", {31'd0, bus.out_valid}, 0);
      chk("t6_ready", {31'd0, bus.in_ready}, 1);
      chk("t6_pc", bus.out_pc, 0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(32'h7777_7777, 32'h600, 1'b1);
      chk("t6_after", bus.out_pc, 32'h600);
      drain();
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction fetch/decode boundary stage for the MIPS pipeline. It buffers fetched instructions in a 2-entry elastic queue with valid/ready handshaking on both sides, and splits the head instruction into its decode fields. The 16-bit immediate field drives the sign extender directly, and the remaining fields feed the register file and control unit. The stage also absorbs back-pressure from decode/execute stalls and implements branch/jump flush.

## Interface
- No parameters; instruction and PC widths are fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- in_instr  in  32  fetched instruction word
- in_pc  in  32  address of in_instr
- flush  in  1  discard all buffered and incoming instructions (taken branch/jump)
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes the head entry this cycle
- out_pc  out  32  PC of the head entry
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32
- out_opcode  out  6  instr[31:26]
- out_rs  out  5  instr[25:21]
- out_rt  out  5  instr[20:16]
- out_rd  out  5  instr[15:11]
- out_shamt  out  5  instr[10:6]
- out_funct  out  6  instr[5:0]
- out_imm  out  16  instr[15:0], feeds the sign extender
- out_jtarget  out  26  instr[25:0]
- out_is_nop  out  1  head instruction == 32'h0000_0000

## Operation
- Storage is two entries of {instr, pc}, with a 1-bit write pointer, a 1-bit read pointer, and a 2-bit count (0..2).
- in_ready = (count != 2), decoded from registered count only. It never depends combinationally on out_ready.
- Push occurs when in_valid & in_ready. The entry is written at wr_ptr, then wr_ptr toggles.
- Pop occurs when out_valid & out_ready. rd_ptr toggles.
- out_valid = (count != 0).
- When out_valid=1, all out_* fields come from the entry at rd_ptr. When out_valid=0, all fields and out_is_nop are forced to 0.
- Count update:
  - push only: +1
  - pop only: -1
  - push & pop together: unchanged (only possible at count 1)
  - neither: unchanged
- flush has priority over everything. On the next edge count, wr_ptr and rd_ptr all go to 0. A push in the same cycle is dropped, and a pop in the same cycle has no additional effect.
- Pointer wrap: pointers toggle 1->0 naturally. FIFO order is preserved across the wrap.
- in_valid while in_ready=0: nothing is written. Fetch must hold its data.
- out_pc_plus4 is computed combinationally from the stored PC. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

## Timing
- Reset (async assert, sync-safe deassert):
  - count=0, pointers=0, storage cleared to 0.
  - in_ready=1, out_valid=0, all field outputs 0, out_is_nop=0.
- Latency: an instruction pushed at edge N appears on out_* after edge N. There is no same-cycle bypass from in_instr to outputs.
- Throughput: 1 instruction/cycle sustained with out_ready held high (count oscillates at 1).
- Back-pressure: with out_ready=0, at most two instructions are accepted. in_ready drops the cycle after the second push.
- Flush: out_valid=0 and in_ready=1 in the cycle after flush is sampled. A push in the following cycle proceeds normally.
- Reset asserted mid-operation: outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset then single push:
  - Stimulus: rst_n low, release, in_valid=1 for one cycle with instr 32'h2108_FFFF, pc 32'h0040_0000.
  - Response: next cycle out_valid=1, out_opcode=6'h08, out_rs=8, out_rt=8, out_imm=16'hFFFF, out_pc_plus4=32'h0040_0004.
- Fill under stall:
  - Stimulus: out_ready=0, push A (pc 0x100) then B (pc 0x104).
  - Response: in_ready=0 after the second push, a third in_valid is ignored, out_pc stays 0x100.
  - Follow-up: raise out_ready for two cycles. Response: out_pc 0x100 then 0x104, then out_valid=0.
- Streaming:
  - Stimulus: 8 consecutive pushes with out_ready=1, pc from 0x0 in steps of 4.
  - Response: outputs in order, one per cycle, count never exceeds 1, pointers wrap correctly.
- Flush with simultaneous push:
  - Stimulus: count=2, assert flush together with in_valid (pc 0x200).
  - Response: next cycle out_valid=0 and in_ready=1. Entry 0x200 is never output.
- Boundary fields:
  - Stimulus: push instr 32'h0000_0000, pc 32'hFFFF_FFFC.
  - Response: out_is_nop=1, out_pc_plus4=32'h0000_0000.
  - Follow-up: push 32'h0810_0000. Response: out_opcode=2, out_jtarget=26'h010_0000.
- Async reset mid-stream:
  - Stimulus: drop rst_n between edges while count=2.
  - Response: out_valid=0 and in_ready=1 immediately. After release, the first push appears after one edge.
